// File: rtl/data_source_pkg.sv
// Shared definitions for the data_source_16 word source: state encoding,
// data width and LFSR constants.
package data_source_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StFin  = 2'd2
  } state_e;

  // Feedback taps at bits 15, 13, 12, 10.
  localparam logic [DATA_W-1:0] LfsrTaps    = 16'hB400;
  // All-zero is the LFSR lock-up state, so a zero seed is replaced by this.
  localparam logic [DATA_W-1:0] LfsrSubSeed = 16'h0001;

  // Left-shifting Fibonacci LFSR step; new bit 0 is the XOR of the tapped bits.
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] d);
    return {d[DATA_W-2:0], ^(d & LfsrTaps)};
  endfunction

endpackage

// File: rtl/half_adder_inc16.sv
// 16-bit +1 incrementer built as a ripple chain of half adders.
module half_adder_inc16 (
  input  logic [15:0] a,
  output logic [15:0] sum,
  output logic        carry_out
);

  logic [16:0] carry;

  // Carry-in of 1 at bit 0 turns the half-adder chain into an incrementer.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < 16; i++) begin : g_ha
    assign sum[i]     = a[i] ^ carry[i];
    assign carry[i+1] = a[i] & carry[i];
  end

  assign carry_out = carry[16];

endmodule

// File: rtl/data_source_16.sv
// Burst word source with valid/ready handshake. A START pulse in IDLE emits
// COUNT_LEN words beginning at SEED, each following word produced by a +1
// incrementer or, when DATA_SOURCE_LFSR_EN is defined and MODE=1, a 16-bit LFSR.
// All outputs are registered.
module data_source_16
  import data_source_pkg::*;
#(
  parameter int unsigned         COUNT_LEN = 16,
  parameter logic [DATA_W-1:0]   SEED      = 16'h0001
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              MODE,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUTPUT_DATA,
  output logic              OUT_VALID,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned     CntW    = (COUNT_LEN > 1) ? $clog2(COUNT_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(COUNT_LEN - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0] inc_word;
  logic              unused_carry;
  logic [DATA_W-1:0] next_word;
  logic [DATA_W-1:0] seed_word;

  half_adder_inc16 u_inc (
    .a         (data_q),
    .sum       (inc_word),
    .carry_out (unused_carry)
  );

`ifdef DATA_SOURCE_LFSR_EN
  localparam logic [DATA_W-1:0] LfsrSeed = (SEED == '0) ? LfsrSubSeed : SEED;

  logic mode_q, mode_d;

  // Pattern select: latched mode picks the next word, live MODE picks the seed.
  always_comb begin
    next_word = mode_q ? lfsr_next(data_q) : inc_word;
    seed_word = MODE ? LfsrSeed : SEED;
  end
`else
  logic unused_mode;
  assign unused_mode = MODE;

  // Without the LFSR build, counter mode is the only pattern.
  always_comb begin
    next_word = inc_word;
    seed_word = SEED;
  end
`endif

  // Next-state logic for the IDLE -> SEND -> FIN burst sequence.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
`ifdef DATA_SOURCE_LFSR_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          data_d  = seed_word;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
`ifdef DATA_SOURCE_LFSR_EN
          mode_d  = MODE;
`endif
          state_d = StSend;
        end
      end
      StSend: begin
        if (valid_q && OUT_READY) begin
          if (cnt_q == LastCnt) begin
            // Last word accepted; data_q keeps it until the next burst.
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StFin;
          end else begin
            cnt_d  = cnt_q + CntW'(1);
            data_d = next_word;
          end
        end
      end
      StFin: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef DATA_SOURCE_LFSR_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef DATA_SOURCE_LFSR_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign OUTPUT_DATA = data_q;
  assign OUT_VALID   = valid_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;

endmodule

// File: doc/data_source_16.md
# data_source_16

Clocked 16-bit word source that drives the `OUTPUT_DATA` bus sampled by the team's `CLK`/`RST` stimulus-and-monitor benches. It is the producing end of that interface. A `START` pulse launches a burst of `COUNT_LEN` words, beginning at `SEED`. Words are delivered under a valid/ready handshake. Successive words come from a half-adder-chain incrementer, or optionally from a 16-bit LFSR.

## Interface
- `COUNT_LEN`, default 16: words per burst; legal range ≥1.
- `SEED`, default 16'h0001: first word of every burst.
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: asynchronous, active-low reset.
- `START`  in  1: burst request; sampled only in IDLE.
- `MODE`  in  1: pattern select, sampled with `START`; 0 = counter, 1 = LFSR (LFSR only when the macro is defined).
- `OUT_READY`  in  1: consumer accepts the current word.
- `OUTPUT_DATA`  out  16: current word; valid while `OUT_VALID`=1.
- `OUT_VALID`  out  1: word on `OUTPUT_DATA` is valid.
- `BUSY`  out  1: burst in progress (SEND state).
- `DONE`  out  1: one-cycle pulse after the last transfer.

## Operation
- **States:** IDLE, SEND, FIN.
- **Reset (`RST`=0, asynchronous):**
  - State goes to IDLE.
  - `OUTPUT_DATA`=16'h0000, `OUT_VALID`=0, `BUSY`=0, `DONE`=0.
  - Word counter=0, latched mode=0.
- **IDLE, `START`=1:**
  - `OUTPUT_DATA`<=`SEED` and `OUT_VALID`<=1, `BUSY`<=1.
  - Counter<=0, latch `MODE`, go to SEND.
- **SEND, transfer (`OUT_VALID`&`OUT_READY`):**
  - If counter==`COUNT_LEN`-1: `OUT_VALID`<=0, `BUSY`<=0, `DONE`<=1, go to FIN.
  - Otherwise: counter+1, `OUTPUT_DATA`<=next(`OUTPUT_DATA`).
- **SEND, no transfer:** `OUTPUT_DATA`, `OUT_VALID` and counter hold. The word must stay stable until accepted.
- **FIN:** `DONE`<=0, go to IDLE. `START` is ignored in FIN.
- **`START` outside IDLE:** ignored. `START` held high re-triggers only on return to IDLE.
- **Counter mode next():** `OUTPUT_DATA`+1, modulo 2^16. 16'hFFFF wraps to 16'h0000, with no flag.
- **LFSR mode next():**
  - Shift left; new bit0 = d[15]^d[13]^d[12]^d[10].
  - If `SEED`==0 in LFSR mode, 16'h0001 is loaded instead, because the all-zero state is a lock-up state.
- **`COUNT_LEN`=1:** a single word, then FIN.
- **`OUTPUT_DATA` after a burst:** retains the last transferred word until the next `START`.
- **Reset mid-burst:** the burst is abandoned immediately and all outputs take their reset values. No `DONE` pulse is produced.

## Timing
- **Latency:** `START` sampled at edge N; the first word is valid after edge N, so `OUT_VALID`=1 in cycle N+1.
- **Throughput:** one word per cycle while `OUT_READY`=1.
- **Full burst with `OUT_READY` held high:**
  - `OUT_VALID` high for exactly `COUNT_LEN` cycles.
  - `DONE` high in the following cycle.
  - Back in IDLE one cycle later.
  - The next `START` is accepted at the edge ending that IDLE cycle.
  - Minimum start-to-start spacing is `COUNT_LEN`+2 cycles.
- **Outputs:** all registered, with no combinational path from inputs to outputs. `OUT_READY` affects outputs only at the next edge.
- **Reset release:** synchronisation of reset release is external. The first active edge after release sees IDLE.

## Configuration
- **`DATA_SOURCE_LFSR_EN` defined:**
  - LFSR next-word logic is compiled in.
  - `MODE`=1 selects it, applying the zero-seed substitution above.
- **`DATA_SOURCE_LFSR_EN` undefined:**
  - LFSR logic is absent.
  - The `MODE` port remains, but its value is ignored; counter mode is always used.

## Structure
- **Shared package `data_source_pkg`:**
  - State encoding constants: IDLE=2'd0, SEND=2'd1, FIN=2'd2.
  - `DATA_W`=16.
  - LFSR tap constant 16'hB400.
  - LFSR substitute seed 16'h0001.
- **Sub-module `half_adder_inc16`:**
  - 16-bit +1 built as a ripple chain of half adders.
  - Inputs: `a[15:0]`. Outputs: `sum[15:0]`, `carry_out`. `carry_out` is unused by the top level.
- **Counter width:** max($clog2(`COUNT_LEN`),1) bits.

## Test plan
- **Reset:** `RST`=0 at time 0, released after 2 cycles → all outputs 0 and `BUSY`=0 until `START`.
- **Counter burst:** `SEED`=16'h0001, `COUNT_LEN`=16, `MODE`=0, `OUT_READY`=1, one-cycle `START` → `OUTPUT_DATA` 0x0001..0x0010 on consecutive cycles, then `DONE`=1 for one cycle.
- **Backpressure:** drop `OUT_READY` for 3 cycles on the word 0x0004 → 0x0004 held with `OUT_VALID`=1 for 4 cycles. No word is skipped or duplicated, and there are still 16 transfers in total.
- **Wrap and no-retrigger:**
  - `SEED`=16'hFFFE, `COUNT_LEN`=4 → words FFFE, FFFF, 0000, 0001.
  - A second `START` pulsed during SEND has no effect.
- **LFSR (macro defined):** `MODE`=1, `SEED`=16'h8000 → words 8000, 0001, 0002, 0004. With `SEED`=0, the first word is 0x0001.
- **Reset mid-burst:** `RST`=0 asserted asynchronously on word 5 → `OUT_VALID`/`BUSY` fall immediately with no `DONE`. A fresh `START` after release restarts from `SEED`.
